interrupt_controller_vec: RTL and testbench
===========================================

Name: interrupt_controller_vec

Overview:
Parametrised successor to the single-line interrupt controller, sitting beside the CSR controller in the core. It arbitrates IRQ_NUM interrupt lines by fixed priority, with per-line mask and global MIE. It tracks exception and interrupt nesting through an explicit FSM and produces mcause plus a one-hot acknowledge back to the serviced source on mret.

Parameters:
IRQ_NUM, 16, number of interrupt lines (1..32); index 0 is highest priority.
CAUSE_BASE, 32'h8000_0010, mcause value for line 0; line k reports CAUSE_BASE + k.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
exception_i  in  1  synchronous exception raised by the core this cycle
irq_req_i  in  IRQ_NUM  interrupt request lines, level
mask_i  in  IRQ_NUM  per-line enable (mie CSR bits)
mie_i  in  1  global interrupt enable (mstatus.MIE)
mret_i  in  1  mret executing this cycle
irq_o  out  1  take interrupt this cycle (trap entry)
irq_cause_o  out  32  mcause of the selected or serviced line
irq_ret_o  out  1  mret returns from an interrupt (not from an exception)
irq_ack_o  out  IRQ_NUM  one-hot acknowledge of the serviced line, pulsed with irq_ret_o

Behaviour:
- One clock and one reset; the reset is synchronous and active-high. After reset: state=IDLE, latched index=0, pending=0. Outputs irq_o=0, irq_ret_o=0, irq_ack_o=0, irq_cause_o=CAUSE_BASE.
- cand = irq_req_i (or pending, under the macro) & mask_i & {IRQ_NUM{mie_i}}. sel = lowest set index of cand.
- FSM states: IDLE, EXC, IRQ, IRQ_EXC.
- IDLE:
  - exception_i -> EXC; irq_o=0. The exception wins over a simultaneous interrupt.
  - else if cand!=0: irq_o=1 combinationally, irq_cause_o=CAUSE_BASE+sel this cycle, latch sel -> IRQ.
  - mret_i in IDLE is ignored: no state change, no outputs.
- EXC:
  - mret_i & ~exception_i -> IDLE; irq_ret_o=0.
  - exception_i holds EXC.
  - irq_o is never asserted in EXC.
- IRQ:
  - irq_o=0, because interrupts do not nest.
  - exception_i -> IRQ_EXC, regardless of mret_i.
  - else mret_i: irq_ret_o=1 and irq_ack_o=1<<latched index for that cycle, then -> IDLE.
- IRQ_EXC: mret_i & ~exception_i -> IRQ with irq_ret_o=0, so the exception handler returns first.
- irq_cause_o outside the IDLE-take cycle = CAUSE_BASE + latched index.
- A new interrupt can be taken at the earliest in the cycle after returning to IDLE. There is no IDLE->IRQ transition in the same cycle as an mret.
- Cause arithmetic: 32-bit unsigned add, index zero-extended; no wrap check is required since IRQ_NUM<=32.
- Changes to mask_i or mie_i while in IRQ do not affect the latched index or the ack.
- Reset asserted in any state returns to IDLE on the next edge. Pending bits and the latched index are cleared, and no ack is issued.

Optional Feature:
IRQ_PENDING_LATCH_EN
- Defined:
  - A per-line pending register is set on a rising edge of irq_req_i (previous-sample register, reset 0).
  - It is cleared by irq_ack_o.
  - cand uses pending, so a one-cycle pulse is remembered until serviced.
  - Set and clear on the same line in the same cycle: set wins.
- Undefined: cand uses level irq_req_i directly; no pending or edge registers exist.

Decomposition:
- Package interrupt_pkg holds:
  - the enum irq_state_e {IDLE, EXC, IRQ, IRQ_EXC};
  - the constant IRQ_CAUSE_BASE_DEFAULT;
  - the constant IRQ_NUM_MAX=32.
- Sub-module irq_priority_encoder (parameter N): inputs req[N]; outputs valid and idx[$clog2(N)]; lowest index wins; purely combinational.
- The FSM, latch, and cause/ack logic live in the top module.

Test Plan:
- irq_req_i=16'h0030, mask_i=16'hFFFF, mie_i=1 in IDLE -> irq_o=1 that cycle, irq_cause_o=32'h8000_0014; mret 5 cycles later -> irq_ret_o=1, irq_ack_o=16'h0010.
- exception_i=1 and irq_req_i[0]=1 in the same IDLE cycle -> irq_o=0, state EXC; mret -> irq_ret_o=0; next cycle irq_o=1, cause 32'h8000_0010.
- In IRQ (line 3): exception_i -> IRQ_EXC. First mret -> irq_ret_o=0, state IRQ. Second mret -> irq_ret_o=1, irq_ack_o=16'h0008.
- mie_i=0 with requests pending -> irq_o stays 0. Set mask_i=16'h0004 and mie_i=1 with irq_req_i=16'h0006 -> cause 32'h8000_0012.
- rst_i asserted while in IRQ -> next cycle all outputs at reset values and state IDLE; mret_i then produces no irq_ret_o.
- With IRQ_PENDING_LATCH_EN: 1-cycle pulse on line 7 while in EXC. After the exception mret -> irq_o=1, cause 32'h8000_0017; after the ack the pending bit clears and no re-take occurs.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXC     = 2'd1,
        IRQ     = 2'd2,
        IRQ_EXC = 2'd3
    } irq_state_e;

    localparam logic [31:0] IRQ_CAUSE_BASE_DEFAULT = 32'h8000_0010;
    localparam int unsigned IRQ_NUM_MAX            = 32;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_priority_encoder #(
    parameter int unsigned N = 16,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller_vec.sv
// Vectored fixed-priority interrupt controller with exception/interrupt nesting FSM.
// Optional edge-triggered pending capture: define IRQ_PENDING_LATCH_EN.
module interrupt_controller_vec
    import interrupt_pkg::*;
#(
    parameter int unsigned IRQ_NUM    = 16,
    parameter logic [31:0] CAUSE_BASE = IRQ_CAUSE_BASE_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exception_i,
    input  logic [IRQ_NUM-1:0] irq_req_i,
    input  logic [IRQ_NUM-1:0] mask_i,
    input  logic               mie_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic               irq_ret_o,
    output logic [IRQ_NUM-1:0] irq_ack_o
);

    localparam int unsigned IW = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;

    irq_state_e         state;
    irq_state_e         state_nxt;
    logic [IW-1:0]      lat_idx;
    logic [IW-1:0]      lat_nxt;
    logic [IRQ_NUM-1:0] src;
    logic [IRQ_NUM-1:0] cand;
    logic               sel_valid;
    logic [IW-1:0]      sel_idx;

`ifdef IRQ_PENDING_LATCH_EN
    logic [IRQ_NUM-1:0] pending;
    logic [IRQ_NUM-1:0] req_prev;

    // Rising edges are remembered until acked; a new edge beats a same-cycle ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending  <= '0;
            req_prev <= '0;
        end else begin
            req_prev <= irq_req_i;
            pending  <= (pending & ~irq_ack_o) | (irq_req_i & ~req_prev);
        end
    end

    assign src = pending;
`else
    assign src = irq_req_i;
`endif

    assign cand = src & mask_i & {IRQ_NUM{mie_i}};

    irq_priority_encoder #(.N(IRQ_NUM)) u_prio (
        .req   (cand),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Next-state and trap/return outputs; the take and return strobes are same-cycle.
    always_comb begin
        state_nxt   = state;
        lat_nxt     = lat_idx;
        irq_o       = 1'b0;
        irq_ret_o   = 1'b0;
        irq_ack_o   = '0;
        irq_cause_o = CAUSE_BASE + 32'(lat_idx);

        case (state)
            IDLE: begin
                if (exception_i) begin
                    state_nxt = EXC;
                end else if (sel_valid) begin
                    irq_o       = 1'b1;
                    irq_cause_o = CAUSE_BASE + 32'(sel_idx);
                    lat_nxt     = sel_idx;
                    state_nxt   = IRQ;
                end
            end
            EXC: begin
                if (mret_i && !exception_i) begin
                    state_nxt = IDLE;
                end
            end
            IRQ: begin
                if (exception_i) begin
                    state_nxt = IRQ_EXC;
                end else if (mret_i) begin
                    irq_ret_o = 1'b1;
                    irq_ack_o = IRQ_NUM'(1) << lat_idx;
                    state_nxt = IDLE;
                end
            end
            IRQ_EXC: begin
                if (mret_i && !exception_i) begin
                    state_nxt = IRQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Nothing is taken or acknowledged while reset is held.
        if (rst_i) begin
            irq_o       = 1'b0;
            irq_ret_o   = 1'b0;
            irq_ack_o   = '0;
            irq_cause_o = CAUSE_BASE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            lat_idx <= '0;
        end else begin
            state   <= state_nxt;
            lat_idx <= lat_nxt;
        end
    end

endmodule

// File: tb/tb_interrupt_controller_vec.sv
// Table-driven cycle-by-cycle bench for interrupt_controller_vec (default parameters).
module tb_interrupt_controller_vec;

    logic        clk;
    logic        rst;
    logic        exc;
    logic [15:0] req;
    logic [15:0] mask;
    logic        mie;
    logic        mret;
    logic        irq;
    logic [31:0] cause;
    logic        ret;
    logic [15:0] ack;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        rst;
        logic        exc;
        logic [15:0] req;
        logic [15:0] mask;
        logic        mie;
        logic        mret;
        logic        e_irq;
        logic [31:0] e_cause;
        logic        e_ret;
        logic [15:0] e_ack;
    } vec_t;

    vec_t vecs[$];

    interrupt_controller_vec dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exception_i (exc),
        .irq_req_i   (req),
        .mask_i      (mask),
        .mie_i       (mie),
        .mret_i      (mret),
        .irq_o       (irq),
        .irq_cause_o (cause),
        .irq_ret_o   (ret),
        .irq_ack_o   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic add(input logic r, input logic e, input logic [15:0] q, input logic [15:0] m,
                       input logic ie, input logic mr, input logic ei, input logic [31:0] ec,
                       input logic er, input logic [15:0] ea);
        vec_t v;
        v.rst = r; v.exc = e; v.req = q; v.mask = m; v.mie = ie; v.mret = mr;
        v.e_irq = ei; v.e_cause = ec; v.e_ret = er; v.e_ack = ea;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; exc = 1'b0; req = '0; mask = 16'hFFFF; mie = 1'b1; mret = 1'b0;

        //   rst exc req       mask      mie mret | irq cause          ret ack
        add(1, 0, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0010, 0, 16'h0000);
`ifndef IRQ_PENDING_LATCH_EN
        // take line 4 of 0x0030, mret five cycles later
        add(0, 0, 16'h0030, 16'hFFFF, 1, 0,   1, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0030, 16'hFFFF, 1, 0,   0, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0030, 16'hFFFF, 1, 0,   0, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0030, 16'hFFFF, 1, 0,   0, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0030, 16'hFFFF, 1, 0,   0, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0014, 1, 16'h0010);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0014, 0, 16'h0000);
        // exception beats simultaneous irq; no take in the mret cycle
        add(0, 1, 16'h0001, 16'hFFFF, 1, 0,   0, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0001, 16'hFFFF, 1, 1,   0, 32'h8000_0014, 0, 16'h0000);
        add(0, 0, 16'h0001, 16'hFFFF, 1, 0,   1, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0010, 1, 16'h0001);
        // exception nested inside line 3 handler
        add(0, 0, 16'h0008, 16'hFFFF, 1, 0,   1, 32'h8000_0013, 0, 16'h0000);
        add(0, 1, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0013, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0013, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0013, 1, 16'h0008);
        // global disable, then per-line mask selects line 2
        add(0, 0, 16'h0006, 16'hFFFF, 0, 0,   0, 32'h8000_0013, 0, 16'h0000);
        add(0, 0, 16'h0006, 16'hFFFF, 0, 0,   0, 32'h8000_0013, 0, 16'h0000);
        add(0, 0, 16'h0006, 16'h0004, 1, 0,   1, 32'h8000_0012, 0, 16'h0000);
        add(0, 0, 16'h0006, 16'h0000, 0, 0,   0, 32'h8000_0012, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 1,   0, 32'h8000_0012, 1, 16'h0004);
        // reset while in IRQ, then mret in IDLE is ignored
        add(0, 0, 16'h0020, 16'hFFFF, 1, 0,   1, 32'h8000_0015, 0, 16'h0000);
        add(1, 0, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0080, 16'hFFFF, 1, 0,   1, 32'h8000_0017, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0017, 1, 16'h0080);
        // exception held across mret stays in EXC, no irq in EXC
        add(0, 1, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0017, 0, 16'h0000);
        add(0, 1, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0017, 0, 16'h0000);
        add(0, 0, 16'h0001, 16'hFFFF, 1, 0,   0, 32'h8000_0017, 0, 16'h0000);
        add(0, 0, 16'h0001, 16'hFFFF, 1, 1,   0, 32'h8000_0017, 0, 16'h0000);
        add(0, 0, 16'h0001, 16'hFFFF, 1, 0,   1, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0010, 1, 16'h0001);
`else
        // one-cycle pulse on line 7 during an exception is remembered
        add(0, 1, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0080, 16'hFFFF, 1, 0,   0, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0010, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 0,   1, 32'h8000_0017, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 1,   0, 32'h8000_0017, 1, 16'h0080);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0017, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'hFFFF, 1, 0,   0, 32'h8000_0017, 0, 16'h0000);
`endif

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst  = vecs[i].rst;
            exc  = vecs[i].exc;
            req  = vecs[i].req;
            mask = vecs[i].mask;
            mie  = vecs[i].mie;
            mret = vecs[i].mret;
            @(negedge clk);
            check("irq_o",       i, 32'(irq),   32'(vecs[i].e_irq));
            check("irq_cause_o", i, cause,      vecs[i].e_cause);
            check("irq_ret_o",   i, 32'(ret),   32'(vecs[i].e_ret));
            check("irq_ack_o",   i, 32'(ack),   32'(vecs[i].e_ack));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
